// File: rtl/cnn_pkg.sv
// Fixed-point constants and saturation helper shared by the neuron datapath.
// Every width here is the signed two's-complement neuron format.
package cnn_pkg;

   localparam int CNN_DATA_WIDTH = 16;
   localparam int CNN_FRAC_BITS  = 8;

   // Width to which all saturation inputs are sign-extended before clamping.
   localparam int SAT_W = 64;

   localparam logic signed [CNN_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(CNN_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [CNN_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(CNN_DATA_WIDTH-1){1'b0}}};

   localparam logic signed [SAT_W-1:0] SAT_MAX_W = {{(SAT_W-CNN_DATA_WIDTH){1'b0}}, SAT_MAX};
   localparam logic signed [SAT_W-1:0] SAT_MIN_W = {{(SAT_W-CNN_DATA_WIDTH){1'b1}}, SAT_MIN};

   function automatic logic signed [CNN_DATA_WIDTH-1:0] saturate(input logic signed [SAT_W-1:0] v);
      if (v > SAT_MAX_W)
         return SAT_MAX;
      else if (v < SAT_MIN_W)
         return SAT_MIN;
      else
         return v[CNN_DATA_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// Activation stream, weight-memory read port, bias load and result bus of one neuron.
// in_valid marks a beat and has no ready: every valid beat is consumed; out_valid is a one-cycle strobe.
interface neuron_mac_if
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int ADDR_WIDTH = 10
);

   logic signed [DATA_WIDTH-1:0] in_data;
   logic                         in_valid;
   logic                         w_ren;
   logic        [ADDR_WIDTH-1:0] w_radd;
   logic signed [DATA_WIDTH-1:0] w_data;
   logic                         bias_wen;
   logic signed [DATA_WIDTH-1:0] bias_in;
   logic signed [DATA_WIDTH-1:0] out_data;
   logic                         out_valid;

   modport master (
      output in_data, in_valid, w_data, bias_wen, bias_in,
      input  w_ren, w_radd, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, w_data, bias_wen, bias_in,
      output w_ren, w_radd, out_data, out_valid
   );

endinterface

// File: rtl/sat_adder.sv
// Signed add of two equal-width operands, clamped to the neuron data format.
module sat_adder
   import cnn_pkg::*;
#(
   parameter int IN_W = CNN_DATA_WIDTH
) (
   input  logic signed [IN_W-1:0]           a,
   input  logic signed [IN_W-1:0]           b,
   output logic signed [CNN_DATA_WIDTH-1:0] y
);

   logic signed [IN_W:0]      sum;
   logic signed [SAT_W-1:0]   wide;

   // One guard bit keeps the raw sum exact before clamping.
   assign sum  = {a[IN_W-1], a} + {b[IN_W-1], b};
   assign wide = {{(SAT_W-IN_W-1){sum[IN_W]}}, sum};
   assign y    = saturate(wide);

endmodule

// File: rtl/neuron_mac.sv
// One neuron: weight fetch, fixed-point multiply, saturating accumulate, bias and optional ReLU.
// Four register stages from an accepted beat to its result strobe.
module neuron_mac
   import cnn_pkg::*;
#(
   parameter int NUM_WEIGHT = 3,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = CNN_DATA_WIDTH,
   parameter int FRAC_BITS  = CNN_FRAC_BITS,
   parameter bit RELU_EN    = 1'b1
) (
   input logic         clk,
   input logic         rst,
   neuron_mac_if.slave bus
);

   localparam int PW = 2*DATA_WIDTH;

   logic        [ADDR_WIDTH-1:0] cnt;
   logic                         beat_first;
   logic                         beat_last;
   logic signed [DATA_WIDTH-1:0] in_d;
   logic                         v1, f1, l1;
   logic signed [PW-1:0]         prod;
   logic                         v2, f2, l2;
   logic signed [DATA_WIDTH-1:0] acc;
   logic                         v3, l3;
   logic signed [DATA_WIDTH-1:0] bias;
   logic signed [PW-1:0]         scaled;
   logic signed [PW-1:0]         acc_base;
   logic signed [DATA_WIDTH-1:0] acc_next;
   logic signed [DATA_WIDTH-1:0] res;

   assign bus.w_ren  = bus.in_valid;
   assign bus.w_radd = cnt;
   assign beat_first = (cnt == '0);
   assign beat_last  = (cnt == ADDR_WIDTH'(NUM_WEIGHT-1));

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (bus.in_valid)
         cnt <= beat_last ? '0 : cnt + ADDR_WIDTH'(1);
   end

   // S1 holds the activation one cycle so it meets the registered weight.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_d <= '0;
         v1   <= 1'b0;
         f1   <= 1'b0;
         l1   <= 1'b0;
      end else begin
         in_d <= bus.in_data;
         v1   <= bus.in_valid;
         f1   <= beat_first;
         l1   <= beat_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prod <= '0;
         v2   <= 1'b0;
         f2   <= 1'b0;
         l2   <= 1'b0;
      end else begin
         prod <= PW'(in_d) * PW'(bus.w_data);
         v2   <= v1;
         f2   <= f1;
         l2   <= l1;
      end
   end

   // A first beat adds to zero instead of the stale sum, restarting the dot product.
   assign scaled   = prod >>> FRAC_BITS;
   assign acc_base = f2 ? '0 : {{DATA_WIDTH{acc[DATA_WIDTH-1]}}, acc};

   sat_adder #(.IN_W(PW)) u_acc_add (
      .a (acc_base),
      .b (scaled),
      .y (acc_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         v3  <= 1'b0;
         l3  <= 1'b0;
      end else begin
         if (v2)
            acc <= acc_next;
         v3 <= v2;
         l3 <= l2;
      end
   end

   sat_adder #(.IN_W(DATA_WIDTH)) u_bias_add (
      .a (acc),
      .b (bias),
      .y (res)
   );

   always_ff @(posedge clk) begin
      if (rst)
         bias <= '0;
      else if (bus.bias_wen)
         bias <= bus.bias_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= v3 && l3;
         if (v3 && l3)
            bus.out_data <= (RELU_EN && res[DATA_WIDTH-1]) ? '0 : res;
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: a ReLU and a pass-through instance share one stimulus stream.
module tb_neuron_mac;

   localparam int NW = 3;

   logic clk;
   logic rst;
   int   cyc = 0;

   neuron_mac_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus_r ();
   neuron_mac_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) bus_l ();

   neuron_mac #(.NUM_WEIGHT(NW), .ADDR_WIDTH(10), .DATA_WIDTH(16), .FRAC_BITS(8), .RELU_EN(1'b1))
      u_relu (.clk(clk), .rst(rst), .bus(bus_r));

   neuron_mac #(.NUM_WEIGHT(NW), .ADDR_WIDTH(10), .DATA_WIDTH(16), .FRAC_BITS(8), .RELU_EN(1'b0))
      u_lin (.clk(clk), .rst(rst), .bus(bus_l));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // registered weight memory model, one per instance
   logic signed [15:0] wmem [NW];

   always @(posedge clk) begin
      if (bus_r.w_ren) bus_r.w_data <= wmem[int'(bus_r.w_radd) % NW];
      if (bus_l.w_ren) bus_l.w_data <= wmem[int'(bus_l.w_radd) % NW];
   end

   // scoreboard
   logic signed [15:0] exp_q[$];
   logic signed [15:0] exp_l_q[$];
   int                 exp_cyc_q[$];
   logic signed [15:0] got_q[$];
   logic signed [15:0] got_l_q[$];
   int                 got_cyc_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;
   int last_cyc = 0;

   always @(negedge clk) begin
      if (bus_r.out_valid) begin
         got_q.push_back(bus_r.out_data);
         got_cyc_q.push_back(cyc);
      end
      if (bus_l.out_valid)
         got_l_q.push_back(bus_l.out_data);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // driver tasks
   task automatic drive(input int x, input bit v, input bit bw, input int b);
      @(negedge clk);
      if (v) begin
         check("w_radd", int'(bus_r.w_radd), exp_cnt);
         exp_cnt  = (exp_cnt + 1) % NW;
         last_cyc = cyc;
      end
      bus_r.in_data  = 16'(x);
      bus_l.in_data  = 16'(x);
      bus_r.in_valid = v;
      bus_l.in_valid = v;
      bus_r.bias_wen = bw;
      bus_l.bias_wen = bw;
      bus_r.bias_in  = 16'(b);
      bus_l.bias_in  = 16'(b);
      #1;
      check("w_ren", int'(bus_r.w_ren), int'(v));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0, 0);
   endtask

   task automatic send3(input int a0, input int a1, input int a2);
      drive(a0, 1'b1, 1'b0, 0);
      drive(a1, 1'b1, 1'b0, 0);
      drive(a2, 1'b1, 1'b0, 0);
   endtask

   task automatic expect_out(input int relu_v, input int lin_v);
      exp_q.push_back(16'(relu_v));
      exp_l_q.push_back(16'(lin_v));
      exp_cyc_q.push_back(last_cyc + 4);
   endtask

   task automatic compare_outputs(input string name);
      check({name, "/n_out_relu"}, got_q.size(), exp_q.size());
      check({name, "/n_out_lin"}, got_l_q.size(), exp_l_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check({name, "/out_relu"}, int'(got_q[i]), int'(exp_q[i]));
         check({name, "/out_cycle"}, got_cyc_q[i], exp_cyc_q[i]);
      end
      for (int i = 0; i < exp_l_q.size() && i < got_l_q.size(); i++)
         check({name, "/out_lin"}, int'(got_l_q[i]), int'(exp_l_q[i]));
      if (exp_q.size() > 0)
         check({name, "/hold_relu"}, int'(bus_r.out_data), int'(exp_q[exp_q.size()-1]));
      exp_q.delete();
      exp_l_q.delete();
      exp_cyc_q.delete();
      got_q.delete();
      got_l_q.delete();
      got_cyc_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      bus_r.in_data = '0;  bus_l.in_data = '0;
      bus_r.in_valid = 1'b0; bus_l.in_valid = 1'b0;
      bus_r.bias_wen = 1'b0; bus_l.bias_wen = 1'b0;
      bus_r.bias_in = '0;  bus_l.bias_in = '0;
      wmem = '{256, 256, 256};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst/out_valid", int'(bus_r.out_valid), 0);
      check("rst/out_data", int'(bus_r.out_data), 0);
      check("rst/w_radd", int'(bus_r.w_radd), 0);
      check("rst/w_ren", int'(bus_r.w_ren), 0);

      // basic dot product: 1 + 2 + 3 + bias 1 = 7.0
      drive(0, 1'b0, 1'b1, 256);
      send3(256, 512, 768);
      expect_out(1792, 1792);
      idle(6);
      check("basic/w_radd_wrap", int'(bus_r.w_radd), 0);
      compare_outputs("basic");

      // positive saturation, bias cleared to 0
      drive(0, 1'b0, 1'b1, 0);
      wmem = '{32767, 32767, 32767};
      send3(32767, 32767, 32767);
      expect_out(32767, 32767);
      idle(6);
      compare_outputs("sat_pos");

      // negative saturation
      wmem = '{-32768, -32768, -32768};
      send3(32767, 32767, 32767);
      expect_out(0, -32768);
      idle(6);
      compare_outputs("sat_neg");

      // relu on a small negative sum
      wmem = '{-256, -256, -256};
      send3(256, 256, 256);
      expect_out(0, -768);
      idle(6);
      compare_outputs("relu");

      // gaps inside A, B immediately after A
      wmem = '{256, 256, 256};
      drive(256, 1'b1, 1'b0, 0);
      idle(1);
      drive(256, 1'b1, 1'b0, 0);
      idle(2);
      drive(256, 1'b1, 1'b0, 0);
      expect_out(768, 768);
      send3(512, 512, 512);
      expect_out(1536, 1536);
      idle(6);
      compare_outputs("b2b");

      // bias write coincides with the S4 edge of this vector
      send3(256, 256, 256);
      expect_out(768, 768);
      idle(2);
      drive(0, 1'b0, 1'b1, 1000);
      idle(4);
      compare_outputs("bias_old");
      send3(256, 256, 256);
      expect_out(1768, 1768);
      idle(6);
      compare_outputs("bias_new");

      // abort a vector with reset; bias 1000 must be cleared too
      drive(256, 1'b1, 1'b0, 0);
      drive(256, 1'b1, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      bus_r.in_valid = 1'b0; bus_l.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      #1;
      check("rst_mid/w_radd", int'(bus_r.w_radd), 0);
      idle(2);
      send3(256, 256, 256);
      expect_out(768, 768);
      idle(6);
      compare_outputs("rst_mid");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
